mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the IF and MEM stages' accesses to the single byte-wide synchronous RAM port.
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or splits little-endian data.
- Drives the IF and MEM stall requests that feed the pipeline stall controller.
- Sits between the IF/MEM stages and the top-level RAM bus, directly upstream of the stall controller.

Parameters:
- ADDR_W, 32, width of request and RAM addresses.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; 0 = CPU paused.
- if_req_i  in  1  IF fetch request; held with stable if_addr_i until if_done_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_cancel_i  in  1  abort in-flight fetch (branch redirect).
- if_data_o  out  32  fetched instruction.
- if_done_o  out  1  one-cycle fetch-complete pulse.
- mem_req_i  in  1  MEM load/store request; held with stable operands until mem_done_o.
- mem_we_i  in  1  1 = store.
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr_i  in  ADDR_W  access address.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data, zero-extended.
- mem_done_o  out  1  one-cycle access-complete pulse.
- ram_din_i  in  8  RAM read data; valid the cycle after the address is sampled.
- ram_dout_o  out  8  RAM write data.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write enable.
- if_stall_req_o  out  1  to stall controller.
- mem_stall_req_o  out  1  to stall controller.

Behaviour:
- Reset (rst_n=0, async): state IDLE, counters 0; all outputs 0.
- FSM states:
  - IDLE: accept one request per edge.
    - Accept mem if mem_req_i && !mem_done_o, else if if_if_req_i && !if_done_o (typo-free: if_req_i && !if_done_o).
    - MEM has priority. Go to MEM_RD, MEM_WR or IF_RD.
  - N = bytes of access: IF always 4; MEM 1/2/4 from mem_width_i.
  - Let E0 be the accepting edge.
- Reads (IF_RD, MEM_RD):
  - Byte k address (addr+k, ADDR_W wrap) is on ram_addr_o in the cycle after E_k, for k=0..N-1.
  - ram_din_i is captured into bits [8k+7:8k] at E_{k+2}.
  - done and data are registered and high in the cycle after E_{N+1}. Word read: done 6 cycles after the accept cycle; byte read: 3.
  - Return to IDLE on the same edge.
  - Unused upper bytes of mem_data_o are 0.
  - if_data_o / mem_data_o hold their value until the next completion of the same port.
- Writes (MEM_WR):
  - Byte k of mem_data_i, address addr+k and ram_wr_o=1 are driven in the cycle after E_k.
  - mem_done_o is high in the cycle after E_N, with ram_wr_o=0. Return to IDLE.
- No preemption: an accepted IF read runs to completion even if mem_req_i rises. mem waits and is accepted in the IDLE cycle that follows.
- Done gating: a request whose done_o is high in the current cycle is not re-accepted. The requester drops or changes its request after seeing done.
- if_cancel_i:
  - In IF_RD: next edge goes to IDLE, no if_done_o, if_data_o unchanged.
  - In IDLE on the accept edge: suppresses IF acceptance.
  - In MEM states: ignored.
- Stall outputs (combinational):
  - if_stall_req_o = if_req_i && !if_done_o && !if_cancel_i.
  - mem_stall_req_o = mem_req_i && !mem_done_o.
- rdy=0:
  - All registers hold, except the byte counters, which reset to 0.
  - ram_wr_o forced 0 combinationally.
  - On rdy return, the current transfer restarts from byte 0 (a store rewrites bytes already written).
  - A done pulse in progress holds high until the first rdy=1 cycle, then clears.
- Reset mid-transfer: abandoned immediately; outputs return to reset values.

Test Plan:
- IF word read at 0x1000, RAM bytes 13 05 00 00 -> if_data_o=0x00000513; if_done_o high exactly 1 cycle, 6 cycles after accept; if_stall_req_o high for all prior cycles.
- MEM store half 0xBEEF to 0x2002 -> ram_wr_o high 2 cycles: (0x2002,EF), (0x2003,BE); mem_done_o the cycle after the last write; 0x2004 never written.
- MEM load byte from 0x3001 holding 0xF0 -> mem_data_o=0x000000F0, done 3 cycles after accept.
- if_req_i and mem_req_i rise in the same IDLE cycle -> MEM served first, IF accepted the cycle after mem_done_o. Separately, mem_req_i rising during IF_RD -> IF completes first.
- if_cancel_i pulsed after 2 bytes of a fetch -> no if_done_o, FSM IDLE next cycle, a new fetch at 0x2000 completes normally.
- rdy low for 3 cycles mid word write -> no writes while low, all 4 bytes rewritten from byte 0 after resume. rst_n low mid-read -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for the IF and MEM stages: MEM has priority,
// each 1/2/4-byte access is split into little-endian byte cycles on one RAM port.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_cancel_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_width_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_data_i,
   output logic [31:0]       mem_data_o,
   output logic              mem_done_o,
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic              if_stall_req_o,
   output logic              mem_stall_req_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] IF_RD  = 2'd1;
   localparam logic [1:0] MEM_RD = 2'd2;
   localparam logic [1:0] MEM_WR = 2'd3;

   logic [1:0]        state;
   logic [2:0]        cnt;
   logic [2:0]        nbytes;
   logic [ADDR_W-1:0] base;
   logic [31:0]       rd_buf;

   function automatic logic [2:0] width_bytes(input logic [1:0] w);
      case (w)
         2'b00:   width_bytes = 3'd1;
         2'b01:   width_bytes = 3'd2;
         default: width_bytes = 3'd4;
      endcase
   endfunction

   // Counter value c delivers RAM byte c-1 (one-cycle read latency).
   function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [7:0] b,
                                            input logic [2:0] c);
      put_byte = word;
      case (c)
         3'd1:    put_byte[7:0]   = b;
         3'd2:    put_byte[15:8]  = b;
         3'd3:    put_byte[23:16] = b;
         3'd4:    put_byte[31:24] = b;
         default: put_byte = word;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [2:0] c);
      case (c)
         3'd0:    byte_sel = word[7:0];
         3'd1:    byte_sel = word[15:8];
         3'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         nbytes     <= 3'd0;
         base       <= '0;
         rd_buf     <= 32'd0;
         if_data_o  <= 32'd0;
         if_done_o  <= 1'b0;
         mem_data_o <= 32'd0;
         mem_done_o <= 1'b0;
      end else if (!rdy) begin
         // Paused: everything holds, the transfer restarts from byte 0 on resume.
         cnt <= 3'd0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               cnt    <= 3'd0;
               rd_buf <= 32'd0;
               if (mem_req_i && !mem_done_o) begin
                  state  <= mem_we_i ? MEM_WR : MEM_RD;
                  base   <= mem_addr_i;
                  nbytes <= width_bytes(mem_width_i);
               end else if (if_req_i && !if_done_o && !if_cancel_i) begin
                  state  <= IF_RD;
                  base   <= if_addr_i;
                  nbytes <= 3'd4;
               end
            end
            IF_RD, MEM_RD: begin
               if (state == IF_RD && if_cancel_i) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  rd_buf <= put_byte(rd_buf, ram_din_i, cnt);
                  if (cnt == nbytes) begin
                     state <= IDLE;
                     cnt   <= 3'd0;
                     if (state == IF_RD) begin
                        if_data_o <= put_byte(rd_buf, ram_din_i, cnt);
                        if_done_o <= 1'b1;
                     end else begin
                        mem_data_o <= put_byte(rd_buf, ram_din_i, cnt);
                        mem_done_o <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            MEM_WR: begin
               if (cnt == nbytes - 3'd1) begin
                  state      <= IDLE;
                  cnt        <= 3'd0;
                  mem_done_o <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      ram_addr_o = '0;
      ram_dout_o = 8'd0;
      ram_wr_o   = 1'b0;
      if (state != IDLE) ram_addr_o = base + ADDR_W'(cnt);
      if (state == MEM_WR) begin
         ram_dout_o = byte_sel(mem_data_i, cnt);
         ram_wr_o   = rdy;
      end
   end

   // Reset gating keeps every output at 0 while rst_n is low.
   assign if_stall_req_o  = rst_n && if_req_i && !if_done_o && !if_cancel_i;
   assign mem_stall_req_o = rst_n && mem_req_i && !mem_done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model behind the RAM port.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'd0;
   logic        if_cancel_i = 1'b0;
   logic [31:0] if_data_o;
   logic        if_done_o;
   logic        mem_req_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [1:0]  mem_width_i = 2'b00;
   logic [31:0] mem_addr_i = 32'd0;
   logic [31:0] mem_data_i = 32'd0;
   logic [31:0] mem_data_o;
   logic        mem_done_o;
   logic [7:0]  ram_din_i = 8'd0;
   logic [7:0]  ram_dout_o;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;
   logic        if_stall_req_o;
   logic        mem_stall_req_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  ram     [0:65535];
   bit          wr_mask [0:65535];
   logic [31:0] log_addr[0:63];
   logic [7:0]  log_data[0:63];
   int          wr_cnt = 0;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
      .if_data_o(if_data_o), .if_done_o(if_done_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_width_i(mem_width_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
      .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_addr_o(ram_addr_o),
      .ram_wr_o(ram_wr_o), .if_stall_req_o(if_stall_req_o), .mem_stall_req_o(mem_stall_req_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h1000: init_byte = 8'h13;
         16'h1001: init_byte = 8'h05;
         16'h2000: init_byte = 8'h37;
         16'h2001: init_byte = 8'h12;
         16'h2004: init_byte = 8'h55;
         16'h3000: init_byte = 8'hAA;
         16'h3001: init_byte = 8'hF0;
         16'h3002: init_byte = 8'h77;
         default:  init_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] rd_ram(input logic [15:0] a);
      rd_ram = wr_mask[a] ? ram[a] : init_byte(a);
   endfunction

   always @(posedge clk) begin
      ram_din_i <= rd_ram(ram_addr_o[15:0]);
      if (ram_wr_o) begin
         ram[ram_addr_o[15:0]]     <= ram_dout_o;
         wr_mask[ram_addr_o[15:0]] <= 1'b1;
         log_addr[wr_cnt[5:0]]     <= ram_addr_o;
         log_data[wr_cnt[5:0]]     <= ram_dout_o;
         wr_cnt                    <= wr_cnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({if_data_o, mem_data_o, ram_addr_o} !== 96'd0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h required 0", if_data_o, mem_data_o, ram_addr_o);
      end
      n_checks++;
      if ({if_done_o, mem_done_o, ram_wr_o, ram_dout_o, if_stall_req_o, mem_stall_req_o} !== 13'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b%b%b %h %b%b required all 0", if_done_o, mem_done_o,
                            ram_wr_o, ram_dout_o, if_stall_req_o, mem_stall_req_o);
      end
      tick(); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_if_read();
      tick(); if_addr_i = 32'h1000; if_req_i = 1'b1; #1;
      n_checks++;
      if (if_stall_req_o !== 1'b1) begin n_fail++; $display("FAIL ifrd_stall0: got %b required 1", if_stall_req_o); end
      for (int c = 1; c <= 8; c++) begin
         tick();
         n_checks++;
         if (if_done_o !== (c == 6)) begin n_fail++; $display("FAIL ifrd_done c%0d: got %b required %b", c, if_done_o, c == 6); end
         if (c < 6) begin
            n_checks++;
            if (if_stall_req_o !== 1'b1) begin n_fail++; $display("FAIL ifrd_stall c%0d: got %b required 1", c, if_stall_req_o); end
         end
         if (c == 1 || c == 4) begin
            n_checks++;
            if (ram_addr_o !== 32'h1000 + c - 1) begin n_fail++; $display("FAIL ifrd_addr c%0d: got %h required %h", c, ram_addr_o, 32'h1000 + c - 1); end
         end
         if (c == 6 || c == 8) begin
            n_checks++;
            if (if_data_o !== 32'h00000513) begin n_fail++; $display("FAIL ifrd_data c%0d: got %h required 00000513", c, if_data_o); end
         end
         if (c == 6) if_req_i = 1'b0;
      end
   endtask

   task automatic test_store_half();
      int s;
      s = wr_cnt;
      tick(); mem_we_i = 1'b1; mem_width_i = 2'b01; mem_addr_i = 32'h2002; mem_data_i = 32'h1234BEEF; mem_req_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_checks++;
         if (ram_wr_o !== (c <= 2)) begin n_fail++; $display("FAIL st_wr c%0d: got %b required %b", c, ram_wr_o, c <= 2); end
         n_checks++;
         if (mem_done_o !== (c == 3)) begin n_fail++; $display("FAIL st_done c%0d: got %b required %b", c, mem_done_o, c == 3); end
         if (c == 1) begin
            n_checks++;
            if ({ram_addr_o, ram_dout_o} !== {32'h2002, 8'hEF}) begin n_fail++; $display("FAIL st_b0: got %h,%h required 2002,EF", ram_addr_o, ram_dout_o); end
         end
         if (c == 2) begin
            n_checks++;
            if ({ram_addr_o, ram_dout_o} !== {32'h2003, 8'hBE}) begin n_fail++; $display("FAIL st_b1: got %h,%h required 2003,BE", ram_addr_o, ram_dout_o); end
         end
         if (c == 3) begin mem_req_i = 1'b0; mem_we_i = 1'b0; end
      end
      n_checks++;
      if (wr_cnt - s !== 2) begin n_fail++; $display("FAIL st_count: got %0d required 2", wr_cnt - s); end
      n_checks++;
      if (rd_ram(16'h2004) !== 8'h55) begin n_fail++; $display("FAIL st_2004: got %h required 55", rd_ram(16'h2004)); end
   endtask

   task automatic test_load(input logic [1:0] w, input logic [31:0] a, input logic [31:0] expd, input int lat);
      tick(); mem_we_i = 1'b0; mem_width_i = w; mem_addr_i = a; mem_req_i = 1'b1;
      for (int c = 1; c <= lat + 2; c++) begin
         tick();
         n_checks++;
         if (mem_done_o !== (c == lat)) begin n_fail++; $display("FAIL ld_done %h c%0d: got %b required %b", a, c, mem_done_o, c == lat); end
         if (c == lat) begin
            n_checks++;
            if (mem_data_o !== expd) begin n_fail++; $display("FAIL ld_data %h: got %h required %h", a, mem_data_o, expd); end
            mem_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_priority_same();
      tick();
      mem_we_i = 1'b0; mem_width_i = 2'b00; mem_addr_i = 32'h3001; mem_req_i = 1'b1;
      if_addr_i = 32'h1000; if_req_i = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         n_checks++;
         if (mem_done_o !== (c == 3)) begin n_fail++; $display("FAIL pri_mdone c%0d: got %b required %b", c, mem_done_o, c == 3); end
         n_checks++;
         if (if_done_o !== (c == 9)) begin n_fail++; $display("FAIL pri_idone c%0d: got %b required %b", c, if_done_o, c == 9); end
         if (c == 1 || c == 4) begin
            n_checks++;
            if (ram_addr_o !== (c == 1 ? 32'h3001 : 32'h1000)) begin n_fail++; $display("FAIL pri_addr c%0d: got %h", c, ram_addr_o); end
         end
         if (c == 3) begin
            n_checks++;
            if (mem_data_o !== 32'h000000F0) begin n_fail++; $display("FAIL pri_mdata: got %h required 000000F0", mem_data_o); end
            mem_req_i = 1'b0;
         end
         if (c == 9) begin
            n_checks++;
            if (if_data_o !== 32'h00000513) begin n_fail++; $display("FAIL pri_idata: got %h required 00000513", if_data_o); end
            if_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_no_preempt();
      tick(); if_addr_i = 32'h1000; if_req_i = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         n_checks++;
         if (if_done_o !== (c == 6)) begin n_fail++; $display("FAIL np_idone c%0d: got %b required %b", c, if_done_o, c == 6); end
         n_checks++;
         if (mem_done_o !== (c == 9)) begin n_fail++; $display("FAIL np_mdone c%0d: got %b required %b", c, mem_done_o, c == 9); end
         if (c == 7) begin
            n_checks++;
            if (ram_addr_o !== 32'h3000) begin n_fail++; $display("FAIL np_addr: got %h required 3000", ram_addr_o); end
         end
         if (c == 2) begin mem_we_i = 1'b0; mem_width_i = 2'b00; mem_addr_i = 32'h3000; mem_req_i = 1'b1; end
         if (c == 6) if_req_i = 1'b0;
         if (c == 9) begin
            n_checks++;
            if (mem_data_o !== 32'h000000AA) begin n_fail++; $display("FAIL np_mdata: got %h required 000000AA", mem_data_o); end
            mem_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_cancel();
      tick(); if_addr_i = 32'h1000; if_req_i = 1'b1;
      tick(); tick();
      n_checks++;
      if (ram_addr_o !== 32'h1001) begin n_fail++; $display("FAIL cn_addr: got %h required 1001", ram_addr_o); end
      if_cancel_i = 1'b1; #1;
      n_checks++;
      if (if_stall_req_o !== 1'b0) begin n_fail++; $display("FAIL cn_stall: got %b required 0", if_stall_req_o); end
      tick();
      n_checks++;
      if (ram_addr_o !== 32'd0) begin n_fail++; $display("FAIL cn_idle: got %h required 0", ram_addr_o); end
      if_cancel_i = 1'b0; if_req_i = 1'b0;
      for (int c = 4; c <= 8; c++) begin
         tick();
         n_checks++;
         if (if_done_o !== 1'b0) begin n_fail++; $display("FAIL cn_done c%0d: got %b required 0", c, if_done_o); end
      end
      n_checks++;
      if (if_data_o !== 32'h00000513) begin n_fail++; $display("FAIL cn_data: got %h required 00000513", if_data_o); end
      tick(); if_addr_i = 32'h2000; if_req_i = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         n_checks++;
         if (if_done_o !== (c == 6)) begin n_fail++; $display("FAIL cn_new_done c%0d: got %b required %b", c, if_done_o, c == 6); end
         if (c == 6) begin
            n_checks++;
            if (if_data_o !== 32'hBEEF1237) begin n_fail++; $display("FAIL cn_new_data: got %h required BEEF1237", if_data_o); end
            if_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_rdy_write();
      int s;
      logic [31:0] ea [0:4];
      ea[0] = 32'h4000; ea[1] = 32'h4000; ea[2] = 32'h4001; ea[3] = 32'h4002; ea[4] = 32'h4003;
      s = wr_cnt;
      tick(); mem_we_i = 1'b1; mem_width_i = 2'b10; mem_addr_i = 32'h4000; mem_data_i = 32'h11223344; mem_req_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         n_checks++;
         if (mem_done_o !== (c == 9)) begin n_fail++; $display("FAIL rw_done c%0d: got %b required %b", c, mem_done_o, c == 9); end
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if (ram_wr_o !== 1'b0) begin n_fail++; $display("FAIL rw_paused c%0d: got %b required 0", c, ram_wr_o); end
         end
         if (c == 2) rdy = 1'b0;
         if (c == 5) rdy = 1'b1;
         if (c == 9) begin mem_req_i = 1'b0; mem_we_i = 1'b0; end
      end
      n_checks++;
      if (wr_cnt - s !== 5) begin n_fail++; $display("FAIL rw_count: got %0d required 5", wr_cnt - s); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (log_addr[6'(s + i)] !== ea[i]) begin n_fail++; $display("FAIL rw_log%0d: got %h required %h", i, log_addr[6'(s + i)], ea[i]); end
      end
      n_checks++;
      if ({rd_ram(16'h4003), rd_ram(16'h4002), rd_ram(16'h4001), rd_ram(16'h4000)} !== 32'h11223344) begin
         n_fail++; $display("FAIL rw_ram: got %h%h%h%h required 11223344", rd_ram(16'h4003), rd_ram(16'h4002), rd_ram(16'h4001), rd_ram(16'h4000));
      end
   endtask

   task automatic test_reset_mid();
      tick(); if_addr_i = 32'h1000; if_req_i = 1'b1;
      tick(); tick(); tick();
      rst_n = 1'b0; #1;
      n_checks++;
      if ({if_data_o, mem_data_o, ram_addr_o} !== 96'd0) begin
         n_fail++; $display("FAIL rstmid_data: got %h/%h/%h required 0", if_data_o, mem_data_o, ram_addr_o);
      end
      n_checks++;
      if ({if_done_o, mem_done_o, ram_wr_o, ram_dout_o, if_stall_req_o, mem_stall_req_o} !== 13'd0) begin
         n_fail++; $display("FAIL rstmid_ctrl: got %b%b%b %h %b%b required all 0", if_done_o, mem_done_o,
                            ram_wr_o, ram_dout_o, if_stall_req_o, mem_stall_req_o);
      end
      tick(); if_req_i = 1'b0; rst_n = 1'b1;
      tick();
      n_checks++;
      if (ram_addr_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_idle: got %h required 0", ram_addr_o); end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_store_half();
      test_load(2'b00, 32'h3001, 32'h000000F0, 3);
      test_load(2'b01, 32'h2002, 32'h0000BEEF, 4);
      test_priority_same();
      test_no_preempt();
      test_cancel();
      test_rdy_write();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
